// File: rtl/exec_unit_md_if.sv
// Issue/result bus between decode, the execute unit and writeback.
// The master side (decode/writeback) drives operations in; the slave side is the execute unit.
interface exec_unit_md_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            iValid;
    logic            oReady;
    logic            iFlush;
    logic [2:0]      iFunct3;
    logic            iAlt;
    logic            iMulDiv;
    logic            iUseImm;
    logic [XLEN-1:0] iRs1;
    logic [XLEN-1:0] iRs2;
    logic [XLEN-1:0] iImm;
    logic [4:0]      iRdAddr;
    logic            oValid;
    logic [4:0]      oRdAddr;
    logic [XLEN-1:0] oData;
    logic            oIllegal;

    modport master (
        output iValid, iFlush, iFunct3, iAlt, iMulDiv, iUseImm, iRs1, iRs2, iImm, iRdAddr,
        input  oReady, oValid, oRdAddr, oData, oIllegal
    );

    modport slave (
        input  iValid, iFlush, iFunct3, iAlt, iMulDiv, iUseImm, iRs1, iRs2, iImm, iRdAddr,
        output oReady, oValid, oRdAddr, oData, oIllegal
    );
endinterface

// File: rtl/exec_unit_md.sv
// Integer execute unit: single-cycle ALU, fixed-latency multiply, iterative restoring divide.
// Accepts one op when idle; results are strobed on oValid with no output backpressure.
module exec_unit_md #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MUL_LATENCY = 3,
    parameter bit          ENABLE_M    = 1'b1
) (
    input logic           iClk,
    input logic           iRst,
    exec_unit_md_if.slave bus
);
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      f3_q;
    logic [4:0]      rd_q;
    logic [XLEN:0]   mul_a_q, mul_b_q;
    logic [XLEN-1:0] div_q_q, div_r_q, div_b_q;
    logic            neg_quo_q, neg_rem_q, div_zero_q;
    logic            out_valid_q, out_ill_q;
    logic [XLEN-1:0] out_data_q;
    logic [4:0]      out_rd_q;

    logic            accept, is_m, is_div, illegal, alu_ill;
    logic [XLEN-1:0] op2, alu_res;
    logic [ShW-1:0]  shamt;

    assign bus.oReady   = (state_q == StIdle);
    assign bus.oValid   = out_valid_q;
    assign bus.oIllegal = out_ill_q;
    assign bus.oData    = out_data_q;
    assign bus.oRdAddr  = out_rd_q;

    assign accept = bus.iValid & (state_q == StIdle) & ~bus.iFlush;
    assign is_m   = bus.iMulDiv & ~bus.iUseImm;
    assign is_div = is_m & bus.iFunct3[2];

    always_comb begin
        op2     = bus.iUseImm ? bus.iImm : bus.iRs2;
        shamt   = op2[ShW-1:0];
        alu_res = '0;
        // funct7[5] only has meaning for ADD/SUB and the right shifts.
        alu_ill = bus.iAlt & ~bus.iUseImm;
        unique case (bus.iFunct3)
            3'b000: begin
                alu_res = (bus.iAlt & ~bus.iUseImm) ? bus.iRs1 - op2 : bus.iRs1 + op2;
                alu_ill = 1'b0;
            end
            3'b001: begin
                alu_res = bus.iRs1 << shamt;
                alu_ill = bus.iAlt;
            end
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.iRs1) < $signed(op2))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (bus.iRs1 < op2)};
            3'b100: alu_res = bus.iRs1 ^ op2;
            3'b101: begin
                alu_res = bus.iAlt ? $unsigned($signed(bus.iRs1) >>> shamt) : bus.iRs1 >> shamt;
                alu_ill = 1'b0;
            end
            3'b110: alu_res = bus.iRs1 | op2;
            3'b111: alu_res = bus.iRs1 & op2;
        endcase
        illegal = is_m ? (~ENABLE_M | bus.iAlt) : alu_ill;
    end

    // Multiplier: XLEN+1-bit operands whose top bit encodes the signedness of each source.
    logic [XLEN:0]           ext_a, ext_b, src_a, src_b;
    logic [1:0]              mul_f3;
    logic signed [2*XLEN+1:0] prod;
    logic [XLEN-1:0]         mul_res;

    always_comb begin
        ext_a   = {(bus.iFunct3[1:0] != 2'b11) & bus.iRs1[XLEN-1], bus.iRs1};
        ext_b   = {~bus.iFunct3[1] & bus.iRs2[XLEN-1], bus.iRs2};
        src_a   = (state_q == StIdle) ? ext_a : mul_a_q;
        src_b   = (state_q == StIdle) ? ext_b : mul_b_q;
        mul_f3  = (state_q == StIdle) ? bus.iFunct3[1:0] : f3_q;
        prod    = $signed({{(XLEN+1){src_a[XLEN]}}, src_a}) *
                  $signed({{(XLEN+1){src_b[XLEN]}}, src_b});
        mul_res = (mul_f3 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic            sgn_a, sgn_b;
    logic [XLEN-1:0] mag_a, mag_b, quo, rem, div_res;
    logic [XLEN:0]   r_sh;
    logic [XLEN+1:0] diff;

    always_comb begin
        sgn_a   = ~bus.iFunct3[0] & bus.iRs1[XLEN-1];
        sgn_b   = ~bus.iFunct3[0] & bus.iRs2[XLEN-1];
        mag_a   = sgn_a ? -bus.iRs1 : bus.iRs1;
        mag_b   = sgn_b ? -bus.iRs2 : bus.iRs2;
        r_sh    = {div_r_q, div_q_q[XLEN-1]};
        diff    = {1'b0, r_sh} - {2'b00, div_b_q};
        // Magnitude divide by zero already leaves |rs1| as remainder; only the quotient is forced.
        quo     = div_zero_q ? '1 : (neg_quo_q ? -div_q_q : div_q_q);
        rem     = neg_rem_q ? -div_r_q : div_r_q;
        div_res = f3_q[1] ? rem : quo;
    end

    logic unused_bits;
    assign unused_bits = ^{prod[2*XLEN+1:2*XLEN], diff[XLEN]};

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            f3_q        <= '0;
            rd_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            div_q_q     <= '0;
            div_r_q     <= '0;
            div_b_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ill_q   <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
        end else if (bus.iFlush) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_ill_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_ill_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        f3_q <= bus.iFunct3[1:0];
                        rd_q <= bus.iRdAddr;
                        if (illegal) begin
                            out_valid_q <= 1'b1;
                            out_ill_q   <= 1'b1;
                            out_data_q  <= '0;
                            out_rd_q    <= bus.iRdAddr;
                        end else if (is_div) begin
                            state_q    <= StDiv;
                            cnt_q      <= CntW'(XLEN);
                            div_q_q    <= mag_a;
                            div_r_q    <= '0;
                            div_b_q    <= mag_b;
                            neg_quo_q  <= sgn_a ^ sgn_b;
                            neg_rem_q  <= sgn_a;
                            div_zero_q <= (bus.iRs2 == '0);
                        end else if (is_m && MUL_LATENCY > 1) begin
                            state_q <= StMul;
                            cnt_q   <= CntW'(MUL_LATENCY - 2);
                            mul_a_q <= ext_a;
                            mul_b_q <= ext_b;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= is_m ? mul_res : alu_res;
                            out_rd_q    <= bus.iRdAddr;
                        end
                    end
                end
                StMul: begin
                    if (cnt_q == '0) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b1;
                        out_data_q  <= mul_res;
                        out_rd_q    <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDiv: begin
                    if (cnt_q == '0) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b1;
                        out_data_q  <= div_res;
                        out_rd_q    <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (!diff[XLEN+1]) begin
                            div_r_q <= diff[XLEN-1:0];
                            div_q_q <= {div_q_q[XLEN-2:0], 1'b1};
                        end else begin
                            div_r_q <= r_sh[XLEN-1:0];
                            div_q_q <= {div_q_q[XLEN-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit_md.sv
// Directed bench for exec_unit_md: ALU, MUL/DIV latencies and corner cases, flush, async reset,
// and an ENABLE_M=0 build.
module tb_exec_unit_md;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [4:0] exp_rd;

    exec_unit_md_if #(.XLEN(32)) bus ();
    exec_unit_md_if #(.XLEN(32)) bus0 ();

    exec_unit_md #(.XLEN(32), .MUL_LATENCY(3), .ENABLE_M(1'b1)) dut (
        .iClk(clk), .iRst(rst), .bus(bus)
    );
    exec_unit_md #(.XLEN(32), .MUL_LATENCY(3), .ENABLE_M(1'b0)) dut_nom (
        .iClk(clk), .iRst(rst), .bus(bus0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic alt, input logic md, input logic ui,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rd);
        bus.iValid  = 1'b1;
        bus.iFunct3 = f3;
        bus.iAlt    = alt;
        bus.iMulDiv = md;
        bus.iUseImm = ui;
        bus.iRs1    = a;
        bus.iRs2    = b;
        bus.iImm    = imm;
        bus.iRdAddr = rd;
        exp_rd      = rd;
    endtask

    // Accept edge, then exact-latency check: nothing early, oReady low while busy.
    task automatic run_op(input string tag, input int lat, input logic [31:0] exp,
                          input logic exp_ill);
        logic early;
        early = 1'b0;
        tick();
        bus.iValid = 1'b0;
        for (int k = 1; k < lat; k++) begin
            if (bus.oValid || bus.oReady) early = 1'b1;
            tick();
        end
        if (lat > 1) chk({tag, ":early"}, 32'(early), 32'd0);
        chk({tag, ":valid"}, 32'(bus.oValid), 32'd1);
        chk({tag, ":illegal"}, 32'(bus.oIllegal), 32'(exp_ill));
        chk({tag, ":data"}, bus.oData, exp);
        chk({tag, ":rd"}, 32'(bus.oRdAddr), 32'(exp_rd));
        chk({tag, ":ready"}, 32'(bus.oReady), 32'd1);
    endtask

    initial begin
        logic seen;
        bus.iValid = 1'b0;  bus.iFlush = 1'b0;  bus.iFunct3 = 3'b0;  bus.iAlt = 1'b0;
        bus.iMulDiv = 1'b0; bus.iUseImm = 1'b0; bus.iRs1 = '0; bus.iRs2 = '0; bus.iImm = '0;
        bus.iRdAddr = '0;
        bus0.iValid = 1'b0; bus0.iFlush = 1'b0; bus0.iFunct3 = 3'b0; bus0.iAlt = 1'b0;
        bus0.iMulDiv = 1'b0; bus0.iUseImm = 1'b0; bus0.iRs1 = '0; bus0.iRs2 = '0;
        bus0.iImm = '0; bus0.iRdAddr = '0;
        exp_rd = '0;

        #2 rst = 1'b1;
        #1;
        chk("reset:valid", 32'(bus.oValid), 32'd0);
        chk("reset:illegal", 32'(bus.oIllegal), 32'd0);
        chk("reset:data", bus.oData, 32'd0);
        chk("reset:rd", 32'(bus.oRdAddr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset:ready", 32'(bus.oReady), 32'd1);

        // Back-to-back single-cycle ALU ops
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd1);
        run_op("add", 1, 32'd12, 1'b0);
        drive(3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd2);
        run_op("sub", 1, 32'hFFFF_FFFE, 1'b0);
        drive(3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd3);
        run_op("sra", 1, 32'hF800_0000, 1'b0);
        tick();
        chk("alu:idle_valid", 32'(bus.oValid), 32'd0);

        drive(3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd4);
        run_op("srl", 1, 32'h0800_0000, 1'b0);
        drive(3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd5);
        run_op("slti", 1, 32'd1, 1'b0);
        drive(3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6);
        run_op("sltu", 1, 32'd0, 1'b0);
        drive(3'b000, 1'b1, 1'b0, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFD, 5'd7);
        run_op("addi_alt", 1, 32'd7, 1'b0);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 32'd1, 32'd37, 32'd0, 5'd8);
        run_op("sll", 1, 32'd32, 1'b0);
        drive(3'b100, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 5'd9);
        run_op("xor", 1, 32'h0FF0, 1'b0);
        drive(3'b110, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 5'd10);
        run_op("or", 1, 32'hFFF0, 1'b0);
        drive(3'b111, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 5'd11);
        run_op("and", 1, 32'hF000, 1'b0);
        drive(3'b001, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd12);
        run_op("undef_alu", 1, 32'd0, 1'b1);

        // Multiply: latency 3
        drive(3'b001, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd13);
        run_op("mulh", 3, 32'd0, 1'b0);
        drive(3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd14);
        run_op("mulhu", 3, 32'hFFFF_FFFE, 1'b0);
        drive(3'b010, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd15);
        run_op("mulhsu", 3, 32'hFFFF_FFFF, 1'b0);
        drive(3'b000, 1'b0, 1'b1, 1'b0, 32'd12345, 32'd678, 32'd0, 5'd16);
        run_op("mul", 3, 32'd8369910, 1'b0);

        // Divide: latency XLEN+2 for every operand
        drive(3'b100, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd17);
        run_op("div_neg", 34, 32'hFFFF_FFFD, 1'b0);
        drive(3'b110, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd18);
        run_op("rem_neg", 34, 32'hFFFF_FFFF, 1'b0);
        drive(3'b101, 1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 32'd0, 5'd19);
        run_op("divu_zero", 34, 32'hFFFF_FFFF, 1'b0);
        drive(3'b110, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd20);
        run_op("rem_ovf", 34, 32'd0, 1'b0);
        drive(3'b100, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd21);
        run_op("div_ovf", 34, 32'h8000_0000, 1'b0);
        drive(3'b111, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 32'd0, 5'd22);
        run_op("remu", 34, 32'd2, 1'b0);
        drive(3'b101, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'd0, 5'd23);
        run_op("divu", 34, 32'h0FFF_FFFF, 1'b0);
        drive(3'b100, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'd0, 5'd24);
        run_op("div_zero", 34, 32'hFFFF_FFFF, 1'b0);
        drive(3'b110, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'd0, 5'd25);
        run_op("rem_zero", 34, 32'hFFFF_FFF9, 1'b0);

        // Flush ten cycles into a divide, with an ADD offered alongside
        drive(3'b100, 1'b0, 1'b1, 1'b0, 32'd1000, 32'd3, 32'd0, 5'd26);
        tick();
        bus.iValid = 1'b0;
        repeat (9) tick();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'd50, 32'd50, 32'd0, 5'd27);
        bus.iFlush = 1'b1;
        tick();
        bus.iFlush = 1'b0;
        bus.iValid = 1'b0;
        chk("flush:valid", 32'(bus.oValid), 32'd0);
        chk("flush:ready", 32'(bus.oReady), 32'd1);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd28);
        run_op("add_after_flush", 1, 32'd2, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.oValid) seen = 1'b1;
        end
        chk("flush:no_stale", 32'(seen), 32'd0);

        // Leave a non-zero result on the ENABLE_M=0 unit before the reset
        bus0.iValid = 1'b1; bus0.iFunct3 = 3'b000; bus0.iRs1 = 32'd2; bus0.iRs2 = 32'd3;
        bus0.iRdAddr = 5'd4;
        tick();
        bus0.iValid = 1'b0;
        chk("nom_add:valid", 32'(bus0.oValid), 32'd1);
        chk("nom_add:data", bus0.oData, 32'd5);

        // Asynchronous reset in the middle of a multiply
        drive(3'b000, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 5'd29);
        tick();
        bus.iValid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst:valid", 32'(bus.oValid), 32'd0);
        chk("arst:data", bus.oData, 32'd0);
        chk("arst:rd", 32'(bus.oRdAddr), 32'd0);
        chk("arst:ready", 32'(bus.oReady), 32'd1);
        chk("arst:nom_data", bus0.oData, 32'd0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.oValid) seen = 1'b1;
        end
        chk("arst:no_result", 32'(seen), 32'd0);

        // M op on the ENABLE_M=0 build is flagged illegal one cycle later
        bus0.iValid = 1'b1; bus0.iFunct3 = 3'b000; bus0.iMulDiv = 1'b1; bus0.iRs1 = 32'd3;
        bus0.iRs2 = 32'd4; bus0.iRdAddr = 5'd9;
        tick();
        bus0.iValid = 1'b0;
        chk("nom_mul:valid", 32'(bus0.oValid), 32'd1);
        chk("nom_mul:illegal", 32'(bus0.oIllegal), 32'd1);
        chk("nom_mul:data", bus0.oData, 32'd0);
        chk("nom_mul:rd", 32'(bus0.oRdAddr), 32'd9);
        chk("nom_mul:ready", 32'(bus0.oReady), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
